// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl
// Description : Pipeline sequencing controller. Merges per-stage stall
//               requests into a shared stall vector, turns committed
//               exceptions / ERET into a one-cycle flush plus redirect PC
//               followed by a one-cycle recovery window, and maintains
//               saturating performance counters and a sticky stall watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_ctrl #(
  parameter logic [31:0] VEC_BASE  = 32'h0000_0020,
  parameter logic [31:0] ERET_CODE = 32'h0000_000e,
  parameter int unsigned TIMEOUT   = 1024,
  parameter int unsigned CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallreq_if,
  input  logic             stallreq_id,
  input  logic             stallreq_ex,
  input  logic             stallreq_mem,
  input  logic [31:0]      excepttype_i,
  input  logic [31:0]      cp0_epc_i,
  output logic [5:0]       stall,
  output logic             flush,
  output logic [31:0]      new_pc,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             timeout_o
);

  // run_len only needs to reach TIMEOUT, where it saturates.
  localparam int unsigned    RUN_W   = $clog2(TIMEOUT + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(TIMEOUT);

  typedef enum logic [0:0] {
    ST_RUN     = 1'b0,
    ST_RECOVER = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [5:0]       req_stall;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [RUN_W-1:0] run_len_q, run_len_d;
  logic             timeout_q, timeout_d;

  // Priority-encode stall requests; the deepest requesting stage wins.
  always_comb begin
    req_stall = 6'b000000;
    if (stallreq_mem) begin
      req_stall = 6'b011111;
    end else if (stallreq_ex) begin
      req_stall = 6'b001111;
    end else if (stallreq_id) begin
      req_stall = 6'b000111;
    end else if (stallreq_if) begin
      req_stall = 6'b000111;
    end
  end

  // FSM next state and combinational pipeline controls; reset masks outputs.
  always_comb begin
    state_d = state_q;
    stall   = 6'b000000;
    flush   = 1'b0;
    new_pc  = 32'h0000_0000;
    if (rst) begin
      state_d = ST_RUN;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (excepttype_i != 32'h0000_0000) begin
            // Flush overrides any stall request in the same cycle.
            flush   = 1'b1;
            new_pc  = (excepttype_i == ERET_CODE) ? cp0_epc_i : VEC_BASE;
            state_d = ST_RECOVER;
          end else begin
            stall = req_stall;
          end
        end
        ST_RECOVER: begin
          // Exceptions and stall requests are ignored for this one cycle.
          state_d = ST_RUN;
        end
        default: begin
          state_d = ST_RUN;
        end
      endcase
    end
  end

  // Saturating counters and watchdog next-state values.
  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    run_len_d    = run_len_q;

    if (stall[0] && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    // A NOP enters EX when ID/EX holds but EX/MEM advances.
    if (stall[2] && !stall[3] && (bubble_cnt_q != {CNT_W{1'b1}})) begin
      bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
    end
    if (flush && (flush_cnt_q != {CNT_W{1'b1}})) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    if (stall[0]) begin
      if (run_len_q != RUN_MAX) begin
        run_len_d = run_len_q + RUN_W'(1);
      end
    end else begin
      run_len_d = '0;
    end

    // Sticky: rises on the edge completing the TIMEOUT-th stalled cycle.
    timeout_d = timeout_q | (run_len_d == RUN_MAX);
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_RUN;
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
      flush_cnt_q  <= '0;
      run_len_q    <= '0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
      run_len_q    <= run_len_d;
      timeout_q    <= timeout_d;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
  assign flush_cnt  = flush_cnt_q;
  assign timeout_o  = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_ctrl
// Description : Directed self-checking bench for pipe_ctrl. A second
//               instance with 2-bit counters shares the stimulus so that
//               counter saturation is exercised.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_ctrl;

  logic        clk;
  logic        rst;
  logic        stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
  logic [31:0] excepttype_i, cp0_epc_i;

  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic [31:0] stall_cnt, bubble_cnt, flush_cnt;
  logic        timeout_o;

  logic [5:0]  stall2;
  logic        flush2;
  logic [31:0] new_pc2;
  logic [1:0]  stall_cnt2, bubble_cnt2, flush_cnt2;
  logic        timeout2;

  int nerr = 0;
  int nchk = 0;

  pipe_ctrl #(.TIMEOUT(4), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .stallreq_if(stallreq_if), .stallreq_id(stallreq_id),
    .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem),
    .excepttype_i(excepttype_i), .cp0_epc_i(cp0_epc_i),
    .stall(stall), .flush(flush), .new_pc(new_pc),
    .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt),
    .timeout_o(timeout_o)
  );

  pipe_ctrl #(.TIMEOUT(4), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst),
    .stallreq_if(stallreq_if), .stallreq_id(stallreq_id),
    .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem),
    .excepttype_i(excepttype_i), .cp0_epc_i(cp0_epc_i),
    .stall(stall2), .flush(flush2), .new_pc(new_pc2),
    .stall_cnt(stall_cnt2), .bubble_cnt(bubble_cnt2), .flush_cnt(flush_cnt2),
    .timeout_o(timeout2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison point: immediate assertion, counted and reported.
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next negedge and apply a full input vector.
  task automatic drive(input logic r, input logic [3:0] req, input logic [31:0] exc,
                       input logic [31:0] epc);
    @(negedge clk);
    rst          = r;
    stallreq_mem = req[3];
    stallreq_ex  = req[2];
    stallreq_id  = req[1];
    stallreq_if  = req[0];
    excepttype_i = exc;
    cp0_epc_i    = epc;
    #1;
  endtask

  // Request vector order: {mem, ex, id, if}
  initial begin
    rst = 1'b1;
    {stallreq_mem, stallreq_ex, stallreq_id, stallreq_if} = 4'b0000;
    excepttype_i = 32'h0;
    cp0_epc_i    = 32'h0;

    // Reset masks outputs even with active requests and an exception.
    drive(1'b1, 4'b1000, 32'h1, 32'h1234_5678);
    chk("rst_stall", stall, 6'b000000);
    chk("rst_flush", flush, 1'b0);
    chk("rst_newpc", new_pc, 32'h0);
    drive(1'b1, 4'b0000, 32'h0, 32'h0);

    drive(1'b0, 4'b0000, 32'h0, 32'h0);
    chk("rst_stall_cnt", stall_cnt, 32'd0);
    chk("rst_bubble_cnt", bubble_cnt, 32'd0);
    chk("rst_flush_cnt", flush_cnt, 32'd0);
    chk("rst_timeout", timeout_o, 1'b0);
    chk("idle_stall", stall, 6'b000000);

    // Priority: if+id+ex for 3 cycles -> EX encoding, no bubbles.
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 4'b0111, 32'h0, 32'h0);
      chk("prio_ex", stall, 6'b001111);
    end
    drive(1'b0, 4'b0000, 32'h0, 32'h0);
    chk("prio_release", stall, 6'b000000);
    chk("prio_stall_cnt", stall_cnt, 32'd3);
    chk("prio_bubble_cnt", bubble_cnt, 32'd0);

    // ID alone for 2 cycles -> load-use bubbles.
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 4'b0010, 32'h0, 32'h0);
      chk("prio_id", stall, 6'b000111);
    end
    drive(1'b0, 4'b0000, 32'h0, 32'h0);
    chk("id_bubble_cnt", bubble_cnt, 32'd2);
    chk("id_stall_cnt", stall_cnt, 32'd5);
    chk("id_timeout", timeout_o, 1'b0);

    // IF alone shares the ID encoding.
    drive(1'b0, 4'b0001, 32'h0, 32'h0);
    chk("prio_if", stall, 6'b000111);
    drive(1'b0, 4'b0000, 32'h0, 32'h0);
    chk("if_bubble_cnt", bubble_cnt, 32'd3);

    // MEM beats EX; release drops stall in the same cycle.
    drive(1'b0, 4'b1100, 32'h0, 32'h0);
    chk("mem_wins", stall, 6'b011111);
    drive(1'b0, 4'b0000, 32'h0, 32'h0);
    chk("mem_release", stall, 6'b000000);
    chk("mem_stall_cnt", stall_cnt, 32'd7);
    chk("mem_bubble_cnt", bubble_cnt, 32'd3);

    // Exception against a MEM stall request.
    drive(1'b0, 4'b1000, 32'h1, 32'h0);
    chk("exc_flush", flush, 1'b1);
    chk("exc_stall", stall, 6'b000000);
    chk("exc_newpc", new_pc, 32'h0000_0020);
    drive(1'b0, 4'b1000, 32'h1, 32'h0);
    chk("recover_flush", flush, 1'b0);
    chk("recover_stall", stall, 6'b000000);
    chk("recover_newpc", new_pc, 32'h0);
    drive(1'b0, 4'b1000, 32'h0, 32'h0);
    chk("post_recover_stall", stall, 6'b011111);
    chk("exc_flush_cnt", flush_cnt, 32'd1);
    chk("exc_stall_cnt", stall_cnt, 32'd7);

    // ERET redirects to EPC.
    drive(1'b0, 4'b0000, 32'h0000_000e, 32'hBFC0_0100);
    chk("eret_flush", flush, 1'b1);
    chk("eret_newpc", new_pc, 32'hBFC0_0100);
    chk("eret_stall_cnt", stall_cnt, 32'd8);
    drive(1'b0, 4'b0000, 32'h0000_000e, 32'hBFC0_0100);
    chk("eret_recover_flush", flush, 1'b0);
    // Honoured again two cycles after the flush; non-ERET code ignores EPC.
    drive(1'b0, 4'b0000, 32'h0000_000f, 32'hBFC0_0100);
    chk("exc2_flush", flush, 1'b1);
    chk("exc2_newpc", new_pc, 32'h0000_0020);
    chk("exc2_flush_cnt", flush_cnt, 32'd2);
    drive(1'b0, 4'b0000, 32'h0, 32'h0);
    drive(1'b0, 4'b0000, 32'h0, 32'h0);
    chk("exc2_flush_cnt_after", flush_cnt, 32'd3);

    // Watchdog: 3 stalled, 1 free, then 4 stalled.
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 4'b0100, 32'h0, 32'h0);
    end
    drive(1'b0, 4'b0000, 32'h0, 32'h0);
    chk("wd_first_run", timeout_o, 1'b0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 4'b0100, 32'h0, 32'h0);
      chk("wd_second_run", timeout_o, 1'b0);
    end
    drive(1'b0, 4'b0000, 32'h0, 32'h0);
    chk("wd_trip", timeout_o, 1'b1);
    chk("wd_stall_cnt", stall_cnt, 32'd15);
    chk("wd_not_forced", stall, 6'b000000);
    drive(1'b0, 4'b0000, 32'h0, 32'h0);
    chk("wd_sticky", timeout_o, 1'b1);

    // Narrow counters saturate instead of wrapping.
    chk("sat_stall_cnt", stall_cnt2, 2'd3);
    chk("sat_bubble_cnt", bubble_cnt2, 2'd3);

    // Reset asserted during RECOVER.
    drive(1'b0, 4'b0000, 32'h1, 32'h0);
    chk("pre_rst_flush", flush, 1'b1);
    drive(1'b1, 4'b1000, 32'h1, 32'h0);
    chk("rst_recover_flush", flush, 1'b0);
    chk("rst_recover_stall", stall, 6'b000000);
    chk("pre_rst_flush_cnt", flush_cnt, 32'd4);
    chk("sat_flush_cnt", flush_cnt2, 2'd3);
    drive(1'b0, 4'b0000, 32'h1, 32'h0);
    chk("post_rst_flush", flush, 1'b1);
    chk("post_rst_newpc", new_pc, 32'h0000_0020);
    chk("post_rst_stall_cnt", stall_cnt, 32'd0);
    chk("post_rst_flush_cnt", flush_cnt, 32'd0);
    chk("post_rst_timeout", timeout_o, 1'b0);
    drive(1'b0, 4'b0000, 32'h0, 32'h0);
    chk("post_rst_flush_cnt1", flush_cnt, 32'd1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
`default_nettype wire
